core_config_loader: RTL and testbench

- Upstream feeder of the core run-state controller.
- While the controller holds the core in reset (initial-on phase), this block receives a program image as a byte stream and writes it into instruction memory as 32-bit words.
- It then raises config_done, which moves the core to ON.
- Sits between the serial byte receiver and the imem write port.

---
 rtl/core_config_loader.sv | 175 +++++++++++++++++
 tb/tb_core_config_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_config_loader.sv
// Loads a little-endian byte-stream program image (header word N, then N data words) into imem.
// Optional trailing XOR checksum word when CFG_CHECKSUM_EN is defined.
module core_config_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_reset_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              config_done,
   output logic              load_busy,
   output logic              cfg_error
);

   typedef enum logic [2:0] {StIdle, StHdr, StData, StChk, StDone} state_e;

   localparam logic [32:0] MaxWords = 33'(1) << ADDR_W;

   state_e              state_q, state_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [23:0]         word_q, word_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [31:0]         imem_wdata_q, imem_wdata_d;
   logic                config_done_q, config_done_d;
   logic                cfg_error_q, cfg_error_d;

   logic                accept, word_done, last_word;
   logic [31:0]         full_word;

   assign accept    = rx_valid && !core_reset_n &&
                      (state_q == StHdr || state_q == StData || state_q == StChk);
   assign word_done = accept && (byte_cnt_q == 2'd3);
   assign full_word = {rx_data, word_q};
   assign last_word = (idx_q == last_q);

`ifdef CFG_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;
   logic        csum_ok;
   assign csum_ok = (full_word == csum_q);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         byte_cnt_q    <= '0;
         word_q        <= '0;
         idx_q         <= '0;
         last_q        <= '0;
         imem_we_q     <= 1'b0;
         imem_addr_q   <= '0;
         imem_wdata_q  <= '0;
         config_done_q <= 1'b0;
         cfg_error_q   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
         csum_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         word_q        <= word_d;
         idx_q         <= idx_d;
         last_q        <= last_d;
         imem_we_q     <= imem_we_d;
         imem_addr_q   <= imem_addr_d;
         imem_wdata_q  <= imem_wdata_d;
         config_done_q <= config_done_d;
         cfg_error_q   <= cfg_error_d;
`ifdef CFG_CHECKSUM_EN
         csum_q        <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (!core_reset_n) state_d = StHdr;
         StHdr: begin
            if (word_done) begin
`ifdef CFG_CHECKSUM_EN
               state_d = (full_word == 32'd0) ? StChk : StData;
`else
               state_d = (full_word == 32'd0) ? StDone : StData;
`endif
            end
         end
         StData: begin
            if (word_done && last_word) begin
`ifdef CFG_CHECKSUM_EN
               state_d = StChk;
`else
               state_d = StDone;
`endif
            end
         end
         StChk: begin
`ifdef CFG_CHECKSUM_EN
            if (word_done) state_d = csum_ok ? StDone : StHdr;
`endif
         end
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
      // Abort: controller left the load phase, drop everything in flight.
      if (state_q != StIdle && core_reset_n) state_d = StIdle;
   end

   always_comb begin
      imem_we_d     = (state_q == StData) && word_done;
      imem_addr_d   = imem_we_d ? idx_q : imem_addr_q;
      imem_wdata_d  = imem_we_d ? full_word : imem_wdata_q;
      config_done_d = (state_q == StDone) && !core_reset_n;
`ifdef CFG_CHECKSUM_EN
      cfg_error_d   = (state_q == StChk) && word_done && !csum_ok;
`else
      cfg_error_d   = 1'b0;
`endif
      load_busy     = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      idx_d      = idx_q;
      last_d     = last_q;
`ifdef CFG_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      if (state_q == StIdle) begin
         byte_cnt_d = '0;
         idx_d      = '0;
`ifdef CFG_CHECKSUM_EN
         csum_d     = '0;
`endif
      end
      if (accept) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         word_d     = {rx_data, word_q[23:8]};
      end
      if (word_done) begin
         if (state_q == StHdr) begin
            // Clamp the image to the imem size; N >= 2^ADDR_W ends at the top address.
            last_d = ({1'b0, full_word} >= MaxWords) ? '1 : ADDR_W'(full_word - 32'd1);
            idx_d  = '0;
`ifdef CFG_CHECKSUM_EN
            csum_d = full_word;
`endif
         end else if (state_q == StData) begin
            idx_d  = last_word ? idx_q : idx_q + 1'b1;
`ifdef CFG_CHECKSUM_EN
            csum_d = csum_q ^ full_word;
`endif
         end else begin
            idx_d  = '0;
`ifdef CFG_CHECKSUM_EN
            csum_d = '0;
`endif
         end
      end
   end

   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign config_done = config_done_q;
   assign cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_core_config_loader.sv
// Directed bench for core_config_loader: a default-size instance and an ADDR_W=2 instance
// share one byte stream; writes are logged per instance on the falling edge.
module tb_core_config_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_reset_n;
   logic        rx_valid;
   logic [7:0]  rx_data;

   logic        we_b, done_b, busy_b, err_b;
   logic [9:0]  addr_b;
   logic [31:0] wdata_b;
   logic        we_s, done_s, busy_s, err_s;
   logic [1:0]  addr_s;
   logic [31:0] wdata_s;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   int unsigned wa_b[$];
   logic [31:0] wd_b[$];
   int unsigned wa_s[$];
   logic [31:0] wd_s[$];

   core_config_loader #(.ADDR_W(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .core_reset_n(core_reset_n),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
      .config_done(done_b), .load_busy(busy_b), .cfg_error(err_b)
   );

   core_config_loader #(.ADDR_W(2)) u_dut_small (
      .clk(clk), .rst_n(rst_n), .core_reset_n(core_reset_n),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
      .config_done(done_s), .load_busy(busy_s), .cfg_error(err_s)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we_b === 1'b1) begin
         wa_b.push_back(int'(addr_b));
         wd_b.push_back(wdata_b);
      end
      if (we_s === 1'b1) begin
         wa_s.push_back(int'(addr_s));
         wd_s.push_back(wdata_s);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic clear_log();
      wa_b.delete(); wd_b.delete(); wa_s.delete(); wd_s.delete();
   endtask

   task automatic check_write_b(input string tag, input int unsigned idx,
                                input int unsigned a, input logic [31:0] d);
      if (idx < wa_b.size()) begin
         check({tag, "_addr"}, 32'(wa_b[idx]), 32'(a));
         check({tag, "_data"}, wd_b[idx], d);
      end else begin
         check({tag, "_present"}, 32'(wa_b.size()), 32'(idx + 1));
      end
   endtask

   task automatic check_write_s(input string tag, input int unsigned idx,
                                input int unsigned a, input logic [31:0] d);
      if (idx < wa_s.size()) begin
         check({tag, "_addr"}, 32'(wa_s[idx]), 32'(a));
         check({tag, "_data"}, wd_s[idx], d);
      end else begin
         check({tag, "_present"}, 32'(wa_s.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      core_reset_n = 1'b1;
      rx_valid     = 1'b0;
      rx_data      = 8'h00;
      tick();
      tick();
      check("rst_we",    32'(we_b), 32'd0);
      check("rst_addr",  32'(addr_b), 32'd0);
      check("rst_wdata", wdata_b, 32'd0);
      check("rst_done",  32'(done_b), 32'd0);
      check("rst_busy",  32'(busy_b), 32'd0);
      check("rst_err",   32'(err_b), 32'd0);
      rst_n = 1'b1;
      tick();

      // Idle with core running: bytes ignored
      clear_log();
      send_word(32'h0000_0001);
      send_word(32'h1234_5678);
      tick();
      check("idle_writes", 32'(wa_b.size()), 32'd0);
      check("idle_busy",   32'(busy_b), 32'd0);

      // Basic load
      core_reset_n = 1'b0;
      tick();
      check("hdr_busy", 32'(busy_b), 32'd1);
      send_word(32'h0000_0002);
      send_word(32'h1122_3344);
      send_word(32'hAABB_CCDD);
      check("basic_we_pulse", 32'(we_b), 32'd1);
      check("basic_we_addr",  32'(addr_b), 32'd1);
`ifdef CFG_CHECKSUM_EN
      send_word(32'hBB99_FF9B);
`endif
      check("basic_done_early", 32'(done_b), 32'd0);
      tick();
      check("basic_done",     32'(done_b), 32'd1);
      check("basic_we_low",   32'(we_b), 32'd0);
      check("basic_busy",     32'(busy_b), 32'd0);
      check("basic_err",      32'(err_b), 32'd0);
      check("basic_nwrites",  32'(wa_b.size()), 32'd2);
      check_write_b("basic_w0", 0, 0, 32'h1122_3344);
      check_write_b("basic_w1", 1, 1, 32'hAABB_CCDD);
      send_byte(8'h5A);
      tick();
      check("basic_done_hold", 32'(done_b), 32'd1);
      check("basic_stray",     32'(wa_b.size()), 32'd2);
      check("basic_small_done", 32'(done_s), 32'd1);
      core_reset_n = 1'b1;
      tick();
      check("basic_done_clr", 32'(done_b), 32'd0);

      // Zero-length image
      core_reset_n = 1'b0;
      tick();
      clear_log();
      send_word(32'h0000_0000);
`ifdef CFG_CHECKSUM_EN
      send_word(32'h0000_0000);
`endif
      tick();
      check("zero_done",    32'(done_b), 32'd1);
      check("zero_writes",  32'(wa_b.size()), 32'd0);
      core_reset_n = 1'b1;
      tick();

      // Clamp: N=9 into a 4-word imem
      core_reset_n = 1'b0;
      tick();
      clear_log();
      send_word(32'h0000_0009);
      for (int i = 1; i <= 4; i++) send_word(32'(i));
`ifdef CFG_CHECKSUM_EN
      send_word(32'h0000_000D);
`endif
      tick();
      check("clamp_done",    32'(done_s), 32'd1);
      check("clamp_nwrites", 32'(wa_s.size()), 32'd4);
      for (int i = 0; i < 4; i++) check_write_s("clamp_w", i, i, 32'(i + 1));
      check("clamp_big_busy", 32'(busy_b), 32'd1);
      core_reset_n = 1'b1;
      tick();

      // Abort after 1.5 words, then restart
      core_reset_n = 1'b0;
      tick();
      clear_log();
      send_word(32'h0000_0004);
      send_word(32'hCAFE_F00D);
      send_byte(8'h11);
      send_byte(8'h22);
      core_reset_n = 1'b1;
      tick();
      send_word(32'h0000_0001);
      tick();
      check("abort_nwrites", 32'(wa_b.size()), 32'd1);
      check_write_b("abort_w0", 0, 0, 32'hCAFE_F00D);
      check("abort_done", 32'(done_b), 32'd0);
      check("abort_busy", 32'(busy_b), 32'd0);
      core_reset_n = 1'b0;
      tick();
      send_word(32'h0000_0001);
      send_word(32'hDEAD_BEEF);
`ifdef CFG_CHECKSUM_EN
      send_word(32'hDEAD_BEEE);
`endif
      tick();
      check("restart_done", 32'(done_b), 32'd1);
      check_write_b("restart_w", 1, 0, 32'hDEAD_BEEF);
      core_reset_n = 1'b1;
      tick();

      // Synchronous reset in the middle of a data word
      core_reset_n = 1'b0;
      tick();
      clear_log();
      send_word(32'h0000_0002);
      send_byte(8'h01);
      rst_n = 1'b0;
      send_byte(8'h02);
      rst_n = 1'b1;
      core_reset_n = 1'b1;
      check("srst_busy", 32'(busy_b), 32'd0);
      check("srst_done", 32'(done_b), 32'd0);
      send_byte(8'h03);
      send_byte(8'h04);
      send_word(32'h0000_0005);
      tick();
      check("srst_writes", 32'(wa_b.size()), 32'd0);

`ifdef CFG_CHECKSUM_EN
      // Checksum good, bad, then corrected resend
      core_reset_n = 1'b0;
      tick();
      clear_log();
      send_word(32'h0000_0001);
      send_word(32'h0000_00F0);
      send_word(32'h0000_00F1);
      tick();
      check("csum_ok_done", 32'(done_b), 32'd1);
      core_reset_n = 1'b1;
      tick();
      core_reset_n = 1'b0;
      tick();
      send_word(32'h0000_0001);
      send_word(32'h0000_00F0);
      send_word(32'h0000_0000);
      check("csum_bad_err", 32'(err_b), 32'd1);
      tick();
      check("csum_bad_err_pulse", 32'(err_b), 32'd0);
      check("csum_bad_done", 32'(done_b), 32'd0);
      check("csum_bad_busy", 32'(busy_b), 32'd1);
      send_word(32'h0000_0001);
      send_word(32'h0000_00F0);
      send_word(32'h0000_00F1);
      tick();
      check("csum_retry_done", 32'(done_b), 32'd1);
      check("csum_nwrites", 32'(wa_b.size()), 32'd3);
      core_reset_n = 1'b1;
      tick();
`else
      check("err_tied_low", 32'(err_b | err_s), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
